// File: rtl/act_quant.sv
// act_quant: per-vector symmetric int8 activation quantizer.
//
// Captures a vector of signed fixed-point elements, finds its absolute
// maximum, divides a scaled 127 by that maximum to get a reciprocal, then
// multiplies every element by the reciprocal and saturates to [-127,127].
// A single FSM sequences the work: IDLE -> MAX -> DIV -> QUANT -> DONE.
// DIV is skipped when absmax is 0.
//
// Compile-time option: define ACT_QUANT_ROUND_EN to round half up in QUANT.
// When it is undefined, QUANT truncates (floor). Latency is the same either way.
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   start      one-cycle request, honoured only in IDLE
//   in_arr     ARR_WIDTH packed signed FXP_N-bit elements (element i at [i*FXP_N +: FXP_N])
//   q_arr      ARR_WIDTH packed signed 8-bit results (element i at [i*8 +: 8])
//   scale_out  absmax of the last completed vector (unsigned)
//   zero_flag  last completed vector had absmax 0
//   busy       high in every state except IDLE
//   done       one-cycle completion pulse
module act_quant #(
  parameter int ARR_WIDTH = 8,
  parameter int FXP_N     = 16,
  parameter int FXP_FRAC  = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [ARR_WIDTH*FXP_N-1:0] in_arr,
  output logic [ARR_WIDTH*8-1:0]     q_arr,
  output logic [FXP_N-1:0]           scale_out,
  output logic                       zero_flag,
  output logic                       busy,
  output logic                       done
);

  localparam int QW = 2*FXP_FRAC + 7;
  localparam int PW = FXP_N + QW + 1;
  localparam int SH = 2*FXP_FRAC;
  localparam int IW = (ARR_WIDTH > 1) ? $clog2(ARR_WIDTH) : 1;
  localparam int CW = $clog2(QW + 1);

  localparam logic [QW-1:0]          DIVIDEND = QW'(127) << SH;
  localparam logic signed [FXP_N-1:0] S_MIN   = {1'b1, {(FXP_N-1){1'b0}}};
  localparam logic [FXP_N-1:0]       S_MAX_U  = {1'b0, {(FXP_N-1){1'b1}}};
  localparam logic signed [PW-1:0]   Q_HI     = PW'(127);
  localparam logic signed [PW-1:0]   Q_LO     = -PW'(127);
  localparam logic [IW-1:0]          LAST     = IW'(ARR_WIDTH - 1);
`ifdef ACT_QUANT_ROUND_EN
  localparam logic signed [PW-1:0]   HALF     = PW'(1) << (SH - 1);
`endif

  typedef enum logic [2:0] {IDLE, MAX, DIV, QUANT, DONE} state_t;

  // |x| with the most negative code clamped to the largest positive code
  function automatic logic [FXP_N-1:0] abs_sat(input logic signed [FXP_N-1:0] x);
    if (x == S_MIN)
      return S_MAX_U;
    else if (x < 0)
      return $unsigned(-x);
    else
      return $unsigned(x);
  endfunction

  function automatic logic signed [PW-1:0] round_shift(input logic signed [PW-1:0] p);
`ifdef ACT_QUANT_ROUND_EN
    return (p + HALF) >>> SH;
`else
    return p >>> SH;
`endif
  endfunction

  function automatic logic signed [7:0] sat8(input logic signed [PW-1:0] s);
    if (s > Q_HI)
      return 8'sd127;
    else if (s < Q_LO)
      return -8'sd127;
    else
      return $signed(s[7:0]);
  endfunction

  state_t                   state;
  logic [IW-1:0]            idx;
  logic [CW-1:0]            dcnt;
  logic [FXP_N-1:0]         absmax;
  logic [QW-1:0]            div_q;     // dividend shifts out, quotient shifts in; holds recip after DIV
  logic [FXP_N-1:0]         div_rem;
  logic signed [FXP_N-1:0]  cap [ARR_WIDTH];
  logic signed [7:0]        wrk [ARR_WIDTH];

  logic [FXP_N-1:0]         elem_abs;
  logic [FXP_N-1:0]         amax_nxt;
  logic [FXP_N:0]           rem_sh;
  logic                     rem_ge;
  logic [FXP_N-1:0]         rem_nxt;
  logic signed [PW-1:0]     x_ext;
  logic signed [PW-1:0]     r_ext;
  logic signed [PW-1:0]     p_cur;
  logic signed [7:0]        q_cur;

  always_comb begin
    elem_abs = abs_sat(cap[idx]);
    amax_nxt = (elem_abs > absmax) ? elem_abs : absmax;

    // Remainder stays below absmax (< 2^(FXP_N-1)), so FXP_N bits hold it
    rem_sh  = {div_rem, div_q[QW-1]};
    rem_ge  = (rem_sh >= {1'b0, absmax});
    rem_nxt = rem_ge ? FXP_N'(rem_sh - {1'b0, absmax}) : rem_sh[FXP_N-1:0];

    x_ext = PW'(cap[idx]);
    r_ext = $signed(PW'(div_q));
    p_cur = x_ext * r_ext;
    q_cur = sat8(round_shift(p_cur));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      idx       <= '0;
      dcnt      <= '0;
      absmax    <= '0;
      div_q     <= '0;
      div_rem   <= '0;
      q_arr     <= '0;
      scale_out <= '0;
      zero_flag <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      for (int i = 0; i < ARR_WIDTH; i++) begin
        cap[i] <= '0;
        wrk[i] <= '0;
      end
    end else begin
      done <= 1'b0;
      case (state)
        // IDLE: capture the vector on start
        IDLE: begin
          if (start) begin
            for (int i = 0; i < ARR_WIDTH; i++)
              cap[i] <= $signed(in_arr[i*FXP_N +: FXP_N]);
            absmax <= '0;
            idx    <= '0;
            busy   <= 1'b1;
            state  <= MAX;
          end
        end
        // MAX: one element per cycle; an all-zero vector skips the divider
        MAX: begin
          absmax <= amax_nxt;
          if (idx == LAST) begin
            idx <= '0;
            if (amax_nxt == '0) begin
              div_q <= '0;
              state <= QUANT;
            end else begin
              div_q   <= DIVIDEND;
              div_rem <= '0;
              dcnt    <= '0;
              state   <= DIV;
            end
          end else begin
            idx <= idx + IW'(1);
          end
        end
        // DIV: restoring divider, one quotient bit per cycle
        DIV: begin
          div_q   <= {div_q[QW-2:0], rem_ge};
          div_rem <= rem_nxt;
          if (dcnt == CW'(QW - 1))
            state <= QUANT;
          else
            dcnt <= dcnt + CW'(1);
        end
        // QUANT: one element per cycle; the last one goes straight to the outputs
        QUANT: begin
          wrk[idx] <= q_cur;
          if (idx == LAST) begin
            for (int i = 0; i < ARR_WIDTH; i++)
              q_arr[i*8 +: 8] <= wrk[i];
            q_arr[(ARR_WIDTH-1)*8 +: 8] <= q_cur;
            scale_out <= absmax;
            zero_flag <= (absmax == '0);
            done      <= 1'b1;
            idx       <= '0;
            state     <= DONE;
          end else begin
            idx <= idx + IW'(1);
          end
        end
        // DONE: done is high for this one cycle; start is not looked at here
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_act_quant.sv
module tb_act_quant;

  localparam int AW = 8;
  localparam int N  = 16;
  localparam int F  = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [AW*N-1:0]   in_arr;
  logic [AW*8-1:0]   q_arr;
  logic [N-1:0]      scale_out;
  logic              zero_flag;
  logic              busy;
  logic              done;

  always #5 clk = ~clk;

  act_quant #(.ARR_WIDTH(AW), .FXP_N(N), .FXP_FRAC(F)) dut (
    .clk(clk), .rst(rst), .start(start), .in_arr(in_arr),
    .q_arr(q_arr), .scale_out(scale_out), .zero_flag(zero_flag),
    .busy(busy), .done(done)
  );

  typedef struct {
    logic [7:0][15:0] din;
    logic [7:0][7:0]  q;
    int               scale;
    bit               zero;
    int               lat;
  } vec_t;

  int          checks = 0;
  int          errors = 0;
  vec_t        sb[$];
  vec_t        tbl[7];
  logic [63:0] last_q;
  int          last_scale;
  int          last_zero;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_i(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [7:0][15:0] v16(input int a0, a1, a2, a3, a4, a5, a6, a7);
    logic [7:0][15:0] r;
    r[0] = 16'(a0); r[1] = 16'(a1); r[2] = 16'(a2); r[3] = 16'(a3);
    r[4] = 16'(a4); r[5] = 16'(a5); r[6] = 16'(a6); r[7] = 16'(a7);
    return r;
  endfunction

  function automatic logic [7:0][7:0] v8(input int a0, a1, a2, a3, a4, a5, a6, a7);
    logic [7:0][7:0] r;
    r[0] = 8'(a0); r[1] = 8'(a1); r[2] = 8'(a2); r[3] = 8'(a3);
    r[4] = 8'(a4); r[5] = 8'(a5); r[6] = 8'(a6); r[7] = 8'(a7);
    return r;
  endfunction

  // Reference: exact integer division and floor/round on 64-bit values
  function automatic vec_t model(input logic [7:0][15:0] d);
    vec_t   v;
    longint am, a, recip, p, q;
    v.din = d;
    am = 0;
    for (int e = 0; e < 8; e++) begin
      a = longint'($signed(d[e]));
      if (a < 0) a = -a;
      if (a > 32767) a = 32767;
      if (a > am) am = a;
    end
    recip = (am == 0) ? 0 : (127 * 65536) / am;
    for (int e = 0; e < 8; e++) begin
      p = longint'($signed(d[e])) * recip;
`ifdef ACT_QUANT_ROUND_EN
      p = p + 32768;
`endif
      q = p >>> 16;
      if (q > 127) q = 127;
      if (q < -127) q = -127;
      v.q[e] = 8'(q);
    end
    v.scale = int'(am);
    v.zero  = (am == 0);
    v.lat   = (am == 0) ? 17 : 40;
    return v;
  endfunction

  // Called at a negedge. mode[0]: re-pulse start in MAX and DIV with a changed in_arr;
  // mode[1]: hold start during the DONE cycle; mode[2]: return right after done for back-to-back.
  task automatic run(input vec_t v, input int mode);
    vec_t e;
    int   lat;
    bit   seen;
    in_arr = v.din;
    start  = 1'b1;
    sb.push_back(v);
    @(negedge clk);
    start = 1'b0;
    chk_i("busy_after_start", int'(busy), 1);
    seen = 1'b0;
    for (lat = 1; lat <= 100; lat++) begin
      if (done) begin
        seen = 1'b1;
        break;
      end
      if (lat == 20) begin
        chk("held_q_arr", q_arr, last_q);
        chk_i("held_scale_out", int'(scale_out), last_scale);
        chk_i("held_zero_flag", int'(zero_flag), last_zero);
      end
      if (mode[0]) begin
        if (lat == 3 || lat == 20) begin
          start  = 1'b1;
          in_arr = ~v.din;
        end else begin
          start = 1'b0;
        end
      end
      @(negedge clk);
    end
    start = 1'b0;
    if (!seen) $display("FAIL done_timeout: got no done expected done within 100 cycles");
    e = sb.pop_front();
    chk_i("latency", lat, e.lat);
    chk("q_arr", q_arr, e.q);
    chk_i("scale_out", int'(scale_out), e.scale);
    chk_i("zero_flag", int'(zero_flag), int'(e.zero));
    last_q     = e.q;
    last_scale = e.scale;
    last_zero  = int'(e.zero);
    if (mode[1]) start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk_i("done_one_cycle", int'(done), 0);
    chk_i("busy_after_done", int'(busy), 0);
    if (!mode[2]) begin
      repeat (3) begin
        @(negedge clk);
        chk_i("idle_busy", int'(busy), 0);
        chk_i("idle_done", int'(done), 0);
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got time limit expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n_done;
    logic [7:0][15:0] d;

    tbl[0].din = v16(256, 256, 256, 256, 256, 256, 256, 256);
    tbl[0].q = v8(127, 127, 127, 127, 127, 127, 127, 127);
    tbl[0].scale = 256; tbl[0].zero = 0; tbl[0].lat = 40;

    tbl[1].din = v16(256, -128, 64, 0, 0, 0, 0, 0);
`ifdef ACT_QUANT_ROUND_EN
    tbl[1].q = v8(127, -63, 32, 0, 0, 0, 0, 0);
`else
    tbl[1].q = v8(127, -64, 31, 0, 0, 0, 0, 0);
`endif
    tbl[1].scale = 256; tbl[1].zero = 0; tbl[1].lat = 40;

    tbl[2].din = v16(0, 0, 0, 0, 0, 0, 0, 0);
    tbl[2].q = v8(0, 0, 0, 0, 0, 0, 0, 0);
    tbl[2].scale = 0; tbl[2].zero = 1; tbl[2].lat = 17;

    tbl[3].din = v16(-32768, 32767, 0, 0, 0, 0, 0, 0);
`ifdef ACT_QUANT_ROUND_EN
    tbl[3].q = v8(-127, 127, 0, 0, 0, 0, 0, 0);
`else
    tbl[3].q = v8(-127, 126, 0, 0, 0, 0, 0, 0);
`endif
    tbl[3].scale = 32767; tbl[3].zero = 0; tbl[3].lat = 40;

    tbl[4].din = v16(100, -50, 25, -1, 1, 0, 200, -200);
`ifdef ACT_QUANT_ROUND_EN
    tbl[4].q = v8(63, -32, 16, -1, 1, 0, 127, -127);
`else
    tbl[4].q = v8(63, -32, 15, -1, 0, 0, 126, -127);
`endif
    tbl[4].scale = 200; tbl[4].zero = 0; tbl[4].lat = 40;

    tbl[5].din = v16(1, 2, 3, -3, 0, 0, 0, 0);
`ifdef ACT_QUANT_ROUND_EN
    tbl[5].q = v8(42, 85, 127, -127, 0, 0, 0, 0);
`else
    tbl[5].q = v8(42, 84, 126, -127, 0, 0, 0, 0);
`endif
    tbl[5].scale = 3; tbl[5].zero = 0; tbl[5].lat = 40;

    tbl[6].din = v16(0, 0, 0, 0, 0, 0, 0, -1);
    tbl[6].q = v8(0, 0, 0, 0, 0, 0, 0, -127);
    tbl[6].scale = 1; tbl[6].zero = 0; tbl[6].lat = 40;

    // Reset, with start held high alongside it
    rst    = 1'b1;
    start  = 1'b1;
    in_arr = tbl[0].din;
    repeat (3) @(negedge clk);
    rst   = 1'b0;
    start = 1'b0;
    chk("reset_q_arr", q_arr, 64'd0);
    chk_i("reset_scale_out", int'(scale_out), 0);
    chk_i("reset_zero_flag", int'(zero_flag), 0);
    chk_i("reset_busy", int'(busy), 0);
    chk_i("reset_done", int'(done), 0);
    @(negedge clk);
    chk_i("start_with_rst_ignored", int'(busy), 0);
    last_q = '0; last_scale = 0; last_zero = 0;

    for (int i = 0; i < 7; i++) run(tbl[i], 0);

    for (int r = 0; r < 4; r++) begin
      for (int e = 0; e < 8; e++) begin
        if (r[0]) d[e] = 16'($urandom_range(0, 600) - 300);
        else      d[e] = 16'($urandom_range(0, 65535));
      end
      run(model(d), 0);
    end

    // Restarts during MAX and DIV with in_arr changed after capture
    run(tbl[4], 1);
    // start held during the DONE cycle
    run(tbl[3], 2);
    // Back-to-back: each start lands on the cycle after done
    run(tbl[5], 4);
    run(tbl[1], 4);
    run(tbl[2], 0);
    run(tbl[0], 0);

    // Reset during QUANT
    in_arr = tbl[5].din;
    start  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (34) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk_i("midrst_busy", int'(busy), 0);
    chk_i("midrst_done", int'(done), 0);
    chk("midrst_q_arr", q_arr, 64'd0);
    chk_i("midrst_scale_out", int'(scale_out), 0);
    chk_i("midrst_zero_flag", int'(zero_flag), 0);
    n_done = 0;
    repeat (50) begin
      @(negedge clk);
      if (done) n_done++;
    end
    chk_i("midrst_no_done", n_done, 0);
    last_q = '0; last_scale = 0; last_zero = 0;
    run(tbl[0], 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
